pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_if.sv | 31 +++
 rtl/pipe_stage_reg.sv | 129 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg.
//   Upstream side  : in_valid, in_ready, in_data, in_ctrl
//   Downstream side: out_valid, out_ready, out_data, out_ctrl
// Modports:
//   master - the environment around the stage (drives in_*, out_ready)
//   slave  - the stage itself (drives in_ready, out_*)
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CTRL_W = 11
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and
// a saturating counter of flushes that killed live beats.
//
// Optional feature: define PIPE_SKID_EN to add a second (skid) entry. In that
// build in_ready is purely registered (skid empty), breaking the
// out_ready -> in_ready combinational path. Without it, in_ready is
// ~out_valid | out_ready.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous, active-high; beats flush and handshakes
//   flush     - discard stage contents (and any beat accepted this cycle)
//   bus       - pipe_stage_reg_if.slave handshake bundle
//   occupancy - beats held (0..2 with skid, 0..1 without)
//   flush_cnt - flush cycles that discarded at least one beat, saturating
module pipe_stage_reg #(
  parameter int unsigned       DATA_W      = 160,
  parameter int unsigned       CTRL_W      = 11,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] flush_cnt
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_accept;
  logic w_drain;     // main register frees up on this edge
  logic w_occupied;

  assign w_drain  = ~r_main_valid | bus.out_ready;
  assign w_accept = bus.in_valid & bus.in_ready;

  assign bus.out_valid = r_main_valid;
  assign bus.out_data  = r_main_data;
  // Kept at BUBBLE_CTRL by every path that clears r_main_valid.
  assign bus.out_ctrl  = r_main_ctrl;
  assign flush_cnt     = r_flush_cnt;

`ifdef PIPE_SKID_EN

  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  assign bus.in_ready = ~r_skid_valid;
  assign occupancy    = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  assign w_occupied   = r_main_valid | r_skid_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_ctrl  <= BUBBLE_CTRL;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= BUBBLE_CTRL;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= BUBBLE_CTRL;
      r_skid_valid <= 1'b0;
    end else if (w_drain) begin
      if (r_skid_valid) begin
        // in_ready was 0, so no accept can collide with the promotion.
        r_main_valid <= 1'b1;
        r_main_data  <= r_skid_data;
        r_main_ctrl  <= r_skid_ctrl;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_data  <= bus.in_data;
        r_main_ctrl  <= bus.in_ctrl;
      end else begin
        r_main_valid <= 1'b0;
        r_main_ctrl  <= BUBBLE_CTRL;
      end
    end else if (w_accept) begin
      // Main is full and stalled: park the new beat behind it.
      r_skid_valid <= 1'b1;
      r_skid_data  <= bus.in_data;
      r_skid_ctrl  <= bus.in_ctrl;
    end
  end

`else

  assign bus.in_ready = w_drain;
  assign occupancy    = {1'b0, r_main_valid};
  assign w_occupied   = r_main_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_ctrl  <= BUBBLE_CTRL;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= BUBBLE_CTRL;
    end else if (w_drain) begin
      if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_data  <= bus.in_data;
        r_main_ctrl  <= bus.in_ctrl;
      end else begin
        r_main_valid <= 1'b0;
        r_main_ctrl  <= BUBBLE_CTRL;
      end
    end
  end

`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_cnt <= '0;
    end else if (flush && w_occupied && (r_flush_cnt != '1)) begin
      r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. The reference model is a queue of
// held beats: front = presented beat, size = occupancy, capacity 1 or 2.
module tb_pipe_stage_reg;

  localparam int unsigned       DW      = 32;
  localparam int unsigned       CW      = 8;
  localparam int unsigned       NW      = 2;
  localparam logic [CW-1:0]     BUB     = 8'h5A;
  localparam int                CNT_MAX = (1 << NW) - 1;
`ifdef PIPE_SKID_EN
  localparam bit                SKID    = 1'b1;
`else
  localparam bit                SKID    = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [1:0]    occupancy;
  logic [NW-1:0] flush_cnt;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_reg #(
    .DATA_W     (DW),
    .CTRL_W     (CW),
    .BUBBLE_CTRL(BUB),
    .CNT_W      (NW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .occupancy(occupancy),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  beat_t q[$];
  int    m_cnt  = 0;
  bit    m_init = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready(input bit ordy);
    return SKID ? (q.size() < 2) : (q.size() == 0 || ordy);
  endfunction

  task automatic check_state(input string tag);
    beat_t h;
    chk({tag, "/valid"}, 64'(bus.out_valid), 64'(q.size() > 0));
    chk({tag, "/occ"},   64'(occupancy),     64'(q.size()));
    chk({tag, "/fcnt"},  64'(flush_cnt),     64'(m_cnt));
    if (q.size() > 0) begin
      h = q[0];
      chk({tag, "/data"}, 64'(bus.out_data), 64'(h.d));
      chk({tag, "/ctrl"}, 64'(bus.out_ctrl), 64'(h.c));
    end else begin
      chk({tag, "/bubble"}, 64'(bus.out_ctrl), 64'(BUB));
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model at the edge,
  // then check registered outputs 1 time unit after the edge.
  task automatic cycle(input string tag, input bit rst, input bit fl, input bit iv,
                       input logic [DW-1:0] d, input logic [CW-1:0] c, input bit ordy);
    bit    rdy;
    bit    acc;
    beat_t b;
    reset         = rst;
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    #1;
    rdy = exp_ready(ordy);
    if (m_init) chk({tag, "/in_ready"}, 64'(bus.in_ready), 64'(rdy));
    acc = iv && rdy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_cnt  = 0;
      m_init = 1'b1;
    end else if (fl) begin
      if (q.size() > 0 && m_cnt < CNT_MAX) m_cnt++;
      q.delete();
    end else begin
      if (ordy && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        b.d = d;
        b.c = c;
        q.push_back(b);
      end
    end
    #1;
    check_state(tag);
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ctrl   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    cycle("reset", 1, 0, 0, 32'h0, 8'h0, 0);
    chk("rst_data",  64'(bus.out_data), 64'h0);
    chk("rst_ready", 64'(bus.in_ready), 64'h1);

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      cycle("stream", 0, 0, 1, DW'(i), CW'(i + 16), 1);
      chk("stream_data",  64'(bus.out_data),  64'(i));
      chk("stream_valid", 64'(bus.out_valid), 64'h1);
    end
    cycle("stream_end", 0, 0, 0, 32'h0, 8'h0, 1);

    // Back-pressure: hold 0xA while 0xB is offered
    cycle("bp_load", 0, 0, 1, 32'hA, 8'h11, 0);
    for (int k = 0; k < 3; k++) begin
      cycle("bp_stall", 0, 0, 1, 32'hB, 8'h22, 0);
      chk("bp_hold", 64'(bus.out_data), 64'hA);
    end
    for (int k = 0; k < 3; k++) cycle("bp_drain", 0, 0, 0, 32'h0, 8'h0, 1);

    // Flush with occupancy 1 and a simultaneous accept of 0xC
    cycle("fl_load", 0, 0, 1, 32'hD, 8'h33, 0);
    cycle("fl_hit", 0, 1, 1, 32'hC, 8'h44, 1);
    chk("fl_cnt1",   64'(flush_cnt),     64'h1);
    chk("fl_bubble", 64'(bus.out_ctrl),  64'(BUB));
    for (int k = 0; k < 2; k++) begin
      cycle("fl_after", 0, 0, 0, 32'h0, 8'h0, 1);
      chk("fl_noC", 64'(bus.out_valid), 64'h0);
    end

    // Flush of an empty stage does not count
    cycle("fl_empty", 0, 1, 0, 32'h0, 8'h0, 0);
    chk("fl_empty_cnt", 64'(flush_cnt), 64'h1);

    // Four more effective flushes: counter saturates at 3
    for (int k = 0; k < 4; k++) begin
      cycle("sat_load", 0, 0, 1, DW'(k + 32'h100), 8'h55, 0);
      cycle("sat_fl",   0, 1, 0, 32'h0, 8'h0, 0);
    end
    chk("fl_sat", 64'(flush_cnt), 64'h3);

    // Reset beats flush while the stage is full
    cycle("rf_load1", 0, 0, 1, 32'h1, 8'h66, 0);
    cycle("rf_load2", 0, 0, 1, 32'h2, 8'h77, 0);
    cycle("rf_hit",   1, 1, 1, 32'h3, 8'h88, 1);
    chk("rf_valid", 64'(bus.out_valid), 64'h0);
    chk("rf_occ",   64'(occupancy),     64'h0);
    chk("rf_cnt",   64'(flush_cnt),     64'h0);
    chk("rf_ready", 64'(bus.in_ready),  64'h1);

    // Randomised traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      cycle("rand",
            ($urandom % 64) == 0,
            ($urandom % 12) == 0,
            ($urandom % 4) != 0,
            DW'($urandom),
            CW'($urandom),
            ($urandom % 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
